demultiplex1_8_seq: RTL and testbench

Sequential 1:8 demultiplexer and deserializer, the receive end of the 8:1 mux serial path. The mux side walks select 0..7 and emits one data bit per slot. This block takes that bit stream, steers bit k into output slot k with its own slot counter, and presents the assembled 8-bit word with a one-cycle DONE strobe. It sits after the serial link, in front of the parallel consumers.

---
 rtl/demultiplex1_8_seq.sv | 128 ++++++++++++
 tb/tb_demultiplex1_8_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/demultiplex1_8_seq.sv
// Sequential 1:8 demultiplexer / deserializer: steers a framed serial bit stream into an 8-bit word.
// Optional macro DEMUX_TRISTATE_EN: Y floats and DONE/ERR are forced low while EN=1.
module demultiplex1_8_seq #(
   parameter bit LSB_FIRST   = 1'b1,
   parameter bit ERR_RESTART = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       EN,
   input  logic       SYNC,
   input  logic       V,
   input  logic       D,
   output logic [2:0] S,
   output logic [7:0] Y,
   output logic       DONE,
   output logic       ERR
);

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   localparam logic [7:0] START_MASK = LSB_FIRST ? 8'h01 : 8'h80;

   state_t     state_reg, state_next;
   logic [2:0] slot_reg, slot_next;
   logic [7:0] shift_reg, shift_next;
   logic [7:0] y_reg, y_next;
   logic       done_reg, done_next;
   logic       err_reg, err_next;

   logic [7:0] wr_mask;
   logic [7:0] written_word;
   logic [7:0] start_word;
   logic       start_frame;
   logic       normal_bit;

   // One-hot bit position written by the current slot, remapped by bit order.
   for (genvar gi = 0; gi < 8; gi++) begin : g_slot_map
      localparam int POS = LSB_FIRST ? gi : 7 - gi;
      assign wr_mask[POS] = (slot_reg == 3'(gi));
   end

   assign written_word = (shift_reg & ~wr_mask) | ({8{D}} & wr_mask);
   assign start_word   = {8{D}} & START_MASK;

   // A SYNC mid-frame only starts a new frame when restart is enabled.
   assign start_frame = !EN && V && SYNC &&
                        ((state_reg == IDLE) || ERR_RESTART);
   assign normal_bit  = !EN && V && (state_reg == COLLECT) &&
                        !(SYNC && ERR_RESTART);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         slot_reg  <= 3'd0;
         shift_reg <= 8'h00;
         y_reg     <= 8'h00;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         slot_reg  <= slot_next;
         shift_reg <= shift_next;
         y_reg     <= y_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (EN) begin
         state_next = IDLE;
      end else if (V) begin
         case (state_reg)
            IDLE: begin
               if (SYNC) state_next = COLLECT;
            end
            COLLECT: begin
               if (SYNC && ERR_RESTART) state_next = COLLECT;
               else if (slot_reg == 3'd7) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      slot_next  = slot_reg;
      shift_next = shift_reg;
      y_next     = y_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;
      if (EN) begin
         slot_next  = 3'd0;
         shift_next = 8'h00;
      end else if (start_frame) begin
         shift_next = start_word;
         slot_next  = 3'd1;
         err_next   = (state_reg == COLLECT);
      end else if (normal_bit) begin
         shift_next = written_word;
         err_next   = SYNC;
         if (slot_reg == 3'd7) begin
            y_next    = written_word;
            done_next = 1'b1;
            slot_next = 3'd0;
         end else begin
            slot_next = slot_reg + 3'd1;
         end
      end
   end

   assign S = slot_reg;

`ifdef DEMUX_TRISTATE_EN
   assign Y    = EN ? 8'bz : y_reg;
   assign DONE = EN ? 1'b0 : done_reg;
   assign ERR  = EN ? 1'b0 : err_reg;
`else
   assign Y    = y_reg;
   assign DONE = done_reg;
   assign ERR  = err_reg;
`endif

endmodule

// File: tb/tb_demultiplex1_8_seq.sv
// Directed bench for demultiplex1_8_seq (default build, LSB_FIRST=1, ERR_RESTART=1).
module tb_demultiplex1_8_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       EN;
   logic       SYNC;
   logic       V;
   logic       D;
   logic [2:0] S;
   logic [7:0] Y;
   logic       DONE;
   logic       ERR;

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [7:0] exp_y        = 8'h00;

   demultiplex1_8_seq #(
      .LSB_FIRST  (1'b1),
      .ERR_RESTART(1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .EN  (EN),
      .SYNC(SYNC),
      .V   (V),
      .D   (D),
      .S   (S),
      .Y   (Y),
      .DONE(DONE),
      .ERR (ERR)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %02h, want %02h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n, input logic [2:0] exp_s);
      for (int k = 0; k < n; k++) begin
         V = 1'b0; SYNC = 1'b0; D = 1'b0;
         tick();
         chk("gap_S", {5'd0, S}, {5'd0, exp_s});
         chk("gap_DONE", {7'd0, DONE}, 8'h00);
      end
   endtask

   // Sends w LSB first, SYNC on bit 0, with optional idle gaps between bits.
   task automatic send_frame(input logic [7:0] w, input int gap, input bit first_err);
      for (int i = 0; i < 8; i++) begin
         if (gap > 0 && i > 0) idle_cycles(gap, 3'(i));
         V = 1'b1; SYNC = (i == 0); D = w[i];
         tick();
         V = 1'b0; SYNC = 1'b0;
         chk("S", {5'd0, S}, (i == 7) ? 8'd0 : 8'(i + 1));
         chk("DONE", {7'd0, DONE}, (i == 7) ? 8'd1 : 8'd0);
         chk("ERR", {7'd0, ERR}, (i == 0 && first_err) ? 8'd1 : 8'd0);
         chk("Y", Y, (i == 7) ? w : exp_y);
      end
      exp_y = w;
      $display("[TB] frame %02h gap=%0d -> Y=%02h", w, gap, Y);
   endtask

   initial begin
      rst = 1'b1; EN = 1'b0; SYNC = 1'b0; V = 1'b0; D = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_Y", Y, 8'h00);
      chk("rst_S", {5'd0, S}, 8'd0);
      chk("rst_DONE", {7'd0, DONE}, 8'd0);
      chk("rst_ERR", {7'd0, ERR}, 8'd0);
      $display("[TB] reset -> Y=%02h S=%0d", Y, S);

      // Valid bit without SYNC in IDLE is dropped.
      V = 1'b1; D = 1'b1;
      tick();
      V = 1'b0;
      chk("idle_drop_S", {5'd0, S}, 8'd0);
      $display("[TB] idle drop -> S=%0d", S);

      send_frame(8'hA5, 0, 1'b0);
      idle_cycles(1, 3'd0);
      chk("A5_hold", Y, 8'hA5);

      send_frame(8'h3C, 0, 1'b0);
      send_frame(8'hC3, 0, 1'b0);
      send_frame(8'hA5, 3, 1'b0);

      // Partial frame of ones, then mid-frame SYNC restarts into 0x5A.
      for (int i = 0; i < 4; i++) begin
         V = 1'b1; SYNC = (i == 0); D = 1'b1;
         tick();
      end
      V = 1'b0; SYNC = 1'b0;
      chk("partial_S", {5'd0, S}, 8'd4);
      chk("partial_Y", Y, 8'hA5);
      send_frame(8'h5A, 0, 1'b1);
      idle_cycles(1, 3'd0);
      chk("restart_ERR_gone", {7'd0, ERR}, 8'd0);

      // Partial frame, then disable for 2 cycles mid-frame.
      for (int i = 0; i < 3; i++) begin
         V = 1'b1; SYNC = (i == 0); D = 1'b0;
         tick();
      end
      V = 1'b1; SYNC = 1'b0; D = 1'b0;
      EN = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("dis_S", {5'd0, S}, 8'd0);
         chk("dis_DONE", {7'd0, DONE}, 8'd0);
         chk("dis_Y", Y, 8'h5A);
      end
      EN = 1'b0; V = 1'b0;
      $display("[TB] disable -> S=%0d Y=%02h", S, Y);
      // A non-SYNC bit after re-enable must not resume the discarded frame.
      V = 1'b1; D = 1'b1;
      tick();
      V = 1'b0;
      chk("reen_S", {5'd0, S}, 8'd0);
      send_frame(8'hFF, 0, 1'b0);
      idle_cycles(2, 3'd0);
      chk("final_Y", Y, 8'hFF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
